// File: rtl/ysyx_23060077_csr_trap_pkg.sv
// Shared constants for the machine-mode CSR file and trap unit.
package ysyx_23060077_csr_trap_pkg;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
  localparam logic [3:0] CAUSE_BREAK     = 4'd3;
  localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;
  localparam logic [3:0] CAUSE_IRQ_TIMER = 4'd7;
  localparam logic [3:0] CAUSE_IRQ_EXT   = 4'd11;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MTIP     = 7;
  localparam int MIP_MEIP     = 11;

  localparam logic [63:0] MSTATUS_WMASK = 64'h0000_0000_0000_0088;
  localparam logic [63:0] MSTATUS_FIXED = 64'h0000_0000_0000_1800;
  localparam logic [63:0] MIE_WMASK     = 64'h0000_0000_0000_0880;
  localparam logic [63:0] MTVEC_WMASK   = ~64'h2;
  localparam logic [63:0] MEPC_WMASK    = ~64'h3;

endpackage

// File: rtl/ysyx_23060077_csr_counter64.sv
// 64-bit event counter with per-half CSR write; a write replaces that cycle's increment.
module ysyx_23060077_csr_counter64 #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_wr_lo,
  input  logic            i_wr_hi,
  input  logic [XLEN-1:0] i_wdata,
  output logic [63:0]     o_value
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 64'(i_inc);
    if (i_wr_lo || i_wr_hi) begin
      cnt_d = cnt_q;
      if (XLEN == 64) begin
        if (i_wr_lo) cnt_d = 64'(i_wdata);
      end else begin
        if (i_wr_lo) cnt_d[31:0]  = i_wdata[31:0];
        if (i_wr_hi) cnt_d[63:32] = i_wdata[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign o_value = cnt_q;

endmodule

// File: rtl/ysyx_23060077_csr_trap.sv
// Machine-mode CSR file and trap unit: CSR access, trap entry/return,
// interrupt pending detection and cycle/instret counters.
module ysyx_23060077_csr_trap
  import ysyx_23060077_csr_trap_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter int              CSR_AW       = 12,
  parameter int              HAS_COUNTERS = 1,
  parameter logic [XLEN-1:0] RESET_MTVEC  = '0,
  parameter logic [XLEN-1:0] HART_ID      = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_csr_valid,
  input  logic [1:0]        i_csr_op,
  input  logic              i_csr_nowrite,
  input  logic [CSR_AW-1:0] i_csr_addr,
  input  logic [XLEN-1:0]   i_csr_wdata,
  output logic [XLEN-1:0]   o_csr_rdata,
  output logic              o_csr_illegal,
  input  logic              i_ecall,
  input  logic              i_ebreak,
  input  logic              i_illegal_inst,
  input  logic              i_mret,
  input  logic              i_irq_take,
  input  logic [XLEN-1:0]   i_pc,
  input  logic [XLEN-1:0]   i_tval,
  input  logic              i_retire,
  input  logic              i_timer_irq,
  input  logic              i_ext_irq,
  output logic              o_irq_pending,
  output logic [XLEN-1:0]   o_trap_pc,
  output logic [XLEN-1:0]   o_mret_pc,
  output logic [XLEN-1:0]   o_mstatus
);

  logic [XLEN-1:0] mstatus_q, mstatus_d, mie_q, mie_d, mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d, mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d, mtval_q, mtval_d;
  logic            mtip_q, mtip_d, meip_q, meip_d;
  logic [63:0]     mcycle, minstret;
  logic [XLEN-1:0] misa_val, mip_val, csr_old, csr_new, vec_base;
  logic            mapped, read_only, wr_req, csr_we, exc;
  logic [3:0]      irq_code, exc_code;
  csr_op_e         op;

  assign op = csr_op_e'(i_csr_op);

  always_comb begin
    misa_val = '0;
    misa_val[XLEN-1 -: 2] = (XLEN == 64) ? 2'b10 : 2'b01;
    misa_val[8] = 1'b1;
    mip_val = '0;
    mip_val[MIP_MTIP] = mtip_q;
    mip_val[MIP_MEIP] = meip_q;
  end

  // The 11 prefix marks the whole 0xC00-0xFFF block read-only.
  always_comb begin
    csr_old   = '0;
    mapped    = 1'b1;
    read_only = (i_csr_addr[CSR_AW-1 -: 2] == 2'b11);
    case (i_csr_addr)
      CSR_AW'(CSR_MSTATUS):  csr_old = mstatus_q;
      CSR_AW'(CSR_MISA):     begin csr_old = misa_val; read_only = 1'b1; end
      CSR_AW'(CSR_MIE):      csr_old = mie_q;
      CSR_AW'(CSR_MTVEC):    csr_old = mtvec_q;
      CSR_AW'(CSR_MSCRATCH): csr_old = mscratch_q;
      CSR_AW'(CSR_MEPC):     csr_old = mepc_q;
      CSR_AW'(CSR_MCAUSE):   csr_old = mcause_q;
      CSR_AW'(CSR_MTVAL):    csr_old = mtval_q;
      CSR_AW'(CSR_MIP):      begin csr_old = mip_val; read_only = 1'b1; end
      CSR_AW'(CSR_MHARTID):  csr_old = HART_ID;
      CSR_AW'(CSR_MCYCLE): begin
        csr_old   = (HAS_COUNTERS != 0) ? XLEN'(mcycle) : '0;
        read_only = (HAS_COUNTERS == 0);
      end
      CSR_AW'(CSR_MINSTRET): begin
        csr_old   = (HAS_COUNTERS != 0) ? XLEN'(minstret) : '0;
        read_only = (HAS_COUNTERS == 0);
      end
      CSR_AW'(CSR_MCYCLEH): begin
        if (XLEN == 32) begin
          csr_old   = (HAS_COUNTERS != 0) ? XLEN'(mcycle[63:32]) : '0;
          read_only = (HAS_COUNTERS == 0);
        end else mapped = 1'b0;
      end
      CSR_AW'(CSR_MINSTRETH): begin
        if (XLEN == 32) begin
          csr_old   = (HAS_COUNTERS != 0) ? XLEN'(minstret[63:32]) : '0;
          read_only = (HAS_COUNTERS == 0);
        end else mapped = 1'b0;
      end
      default: mapped = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      CSR_OP_RW: csr_new = i_csr_wdata;
      CSR_OP_RS: csr_new = csr_old | i_csr_wdata;
      CSR_OP_RC: csr_new = csr_old & ~i_csr_wdata;
      default:   csr_new = csr_old;
    endcase
  end

  assign wr_req = i_csr_valid && (op == CSR_OP_RW ||
                  ((op == CSR_OP_RS || op == CSR_OP_RC) && !i_csr_nowrite));
  assign o_csr_illegal = rst_n && i_csr_valid && (!mapped || (read_only && wr_req));
  assign o_csr_rdata   = (rst_n && i_csr_valid && mapped) ? csr_old : '0;

  assign exc    = i_ecall || i_ebreak || i_illegal_inst;
  assign csr_we = wr_req && !o_csr_illegal && !i_irq_take && !exc && !i_mret;

  assign irq_code = (meip_q && mie_q[MIE_MEIE]) ? CAUSE_IRQ_EXT : CAUSE_IRQ_TIMER;
  assign exc_code = i_illegal_inst ? CAUSE_ILLEGAL : (i_ebreak ? CAUSE_BREAK : CAUSE_ECALL_M);
  assign vec_base = {mtvec_q[XLEN-1:2], 2'b00};
  assign o_trap_pc = (mtvec_q[0] && i_irq_take) ? vec_base + XLEN'({irq_code, 2'b00}) : vec_base;

  assign o_irq_pending = rst_n && mstatus_q[MSTATUS_MIE] && |(mip_val & mie_q);
  assign o_mret_pc     = mepc_q;
  assign o_mstatus     = mstatus_q;

  always_comb begin
    mstatus_d  = mstatus_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mtip_d     = i_timer_irq;
    meip_d     = i_ext_irq;
    if (i_irq_take || exc) begin
      mepc_d                  = i_pc & XLEN'(MEPC_WMASK);
      mstatus_d[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
      mstatus_d[MSTATUS_MIE]  = 1'b0;
      mcause_d                = '0;
      mcause_d[3:0]           = i_irq_take ? irq_code : exc_code;
      mcause_d[XLEN-1]        = i_irq_take;
      if (i_irq_take)          mtval_d = '0;
      else if (i_illegal_inst) mtval_d = i_tval;
      else if (i_ebreak)       mtval_d = i_pc;
      else                     mtval_d = '0;
    end else if (i_mret) begin
      mstatus_d[MSTATUS_MIE]  = mstatus_q[MSTATUS_MPIE];
      mstatus_d[MSTATUS_MPIE] = 1'b1;
    end else if (csr_we) begin
      case (i_csr_addr)
        CSR_AW'(CSR_MSTATUS):  mstatus_d  = (csr_new & XLEN'(MSTATUS_WMASK)) | XLEN'(MSTATUS_FIXED);
        CSR_AW'(CSR_MIE):      mie_d      = csr_new & XLEN'(MIE_WMASK);
        CSR_AW'(CSR_MTVEC):    mtvec_d    = csr_new & XLEN'(MTVEC_WMASK);
        CSR_AW'(CSR_MSCRATCH): mscratch_d = csr_new;
        CSR_AW'(CSR_MEPC):     mepc_d     = csr_new & XLEN'(MEPC_WMASK);
        CSR_AW'(CSR_MCAUSE):   mcause_d   = csr_new;
        CSR_AW'(CSR_MTVAL):    mtval_d    = csr_new;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mstatus_q  <= XLEN'(MSTATUS_FIXED);
      mie_q      <= '0;
      mtvec_q    <= RESET_MTVEC;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
    end else begin
      mstatus_q  <= mstatus_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mtip_q     <= mtip_d;
      meip_q     <= meip_d;
    end
  end

  ysyx_23060077_csr_counter64 #(.XLEN(XLEN)) u_mcycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (1'b1),
    .i_wr_lo (csr_we && i_csr_addr == CSR_AW'(CSR_MCYCLE)),
    .i_wr_hi (csr_we && i_csr_addr == CSR_AW'(CSR_MCYCLEH)),
    .i_wdata (csr_new),
    .o_value (mcycle)
  );

  ysyx_23060077_csr_counter64 #(.XLEN(XLEN)) u_minstret (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (i_retire),
    .i_wr_lo (csr_we && i_csr_addr == CSR_AW'(CSR_MINSTRET)),
    .i_wr_hi (csr_we && i_csr_addr == CSR_AW'(CSR_MINSTRETH)),
    .i_wdata (csr_new),
    .o_value (minstret)
  );

endmodule

// File: tb/tb_ysyx_23060077_csr_trap.sv
// Scoreboard bench for the CSR/trap unit: table of CSR accesses plus
// hand-written trap, interrupt, reset and counter sequences.
module tb_ysyx_23060077_csr_trap;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_csr_valid, i_csr_nowrite;
  logic [1:0]  i_csr_op;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata, o_csr_rdata;
  logic        o_csr_illegal;
  logic        i_ecall, i_ebreak, i_illegal_inst, i_mret, i_irq_take, i_retire;
  logic [31:0] i_pc, i_tval;
  logic        i_timer_irq, i_ext_irq, o_irq_pending;
  logic [31:0] o_trap_pc, o_mret_pc, o_mstatus;

  ysyx_23060077_csr_trap #(
    .XLEN(32), .CSR_AW(12), .HAS_COUNTERS(1), .RESET_MTVEC(32'h0), .HART_ID(32'h0)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_csr_valid(i_csr_valid), .i_csr_op(i_csr_op), .i_csr_nowrite(i_csr_nowrite),
    .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata),
    .o_csr_rdata(o_csr_rdata), .o_csr_illegal(o_csr_illegal),
    .i_ecall(i_ecall), .i_ebreak(i_ebreak), .i_illegal_inst(i_illegal_inst),
    .i_mret(i_mret), .i_irq_take(i_irq_take), .i_pc(i_pc), .i_tval(i_tval),
    .i_retire(i_retire), .i_timer_irq(i_timer_irq), .i_ext_irq(i_ext_irq),
    .o_irq_pending(o_irq_pending), .o_trap_pc(o_trap_pc),
    .o_mret_pc(o_mret_pc), .o_mstatus(o_mstatus)
  );

  always #5 clk = ~clk;

  typedef enum int {SIG_RDATA, SIG_ILL, SIG_PEND, SIG_TRAP, SIG_MRET, SIG_MSTATUS} sig_e;
  typedef struct { string name; sig_e sig; logic [31:0] val; } exp_t;
  typedef struct {
    logic [1:0] op; logic nowrite; logic [11:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; logic ill;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    i_csr_valid = 0; i_csr_op = 2'b00; i_csr_nowrite = 0; i_csr_addr = '0; i_csr_wdata = '0;
    i_ecall = 0; i_ebreak = 0; i_illegal_inst = 0; i_mret = 0; i_irq_take = 0;
    i_pc = '0; i_tval = '0; i_retire = 0; i_timer_irq = 0; i_ext_irq = 0;
  endtask

  task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic nowrite,
                               input logic [11:0] addr, input logic [31:0] wdata);
    i_csr_valid = valid; i_csr_op = op; i_csr_nowrite = nowrite;
    i_csr_addr = addr; i_csr_wdata = wdata;
  endtask

  task automatic pushExp(input string name, input sig_e sig, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sig = sig; e.val = val;
    sb_q.push_back(e);
  endtask

  function automatic logic [31:0] sample(input sig_e s);
    case (s)
      SIG_RDATA: return o_csr_rdata;
      SIG_ILL:   return {31'b0, o_csr_illegal};
      SIG_PEND:  return {31'b0, o_irq_pending};
      SIG_TRAP:  return o_trap_pc;
      SIG_MRET:  return o_mret_pc;
      default:   return o_mstatus;
    endcase
  endfunction

  task automatic checkOutput();
    exp_t e;
    logic [31:0] act;
    #2;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      act = sample(e.sig);
      total++;
      if (act !== e.val) begin
        bad++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.val);
      end
    end
  endtask

  task automatic readCheck(input logic [11:0] addr, input logic [31:0] exp_val);
    clearIn();
    applyStimulus(1'b1, 2'b00, 1'b0, addr, 32'h0);
    pushExp($sformatf("read_%03h", addr), SIG_RDATA, exp_val);
    pushExp($sformatf("legal_%03h", addr), SIG_ILL, 32'h0);
    checkOutput();
    step();
  endtask

  task automatic writeCsr(input logic [11:0] addr, input logic [31:0] data);
    clearIn();
    applyStimulus(1'b1, 2'b01, 1'b0, addr, data);
    checkOutput();
    step();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs.push_back('{2'b01, 1'b0, 12'h340, 32'h0000A5A5, 32'h00000000, 1'b0});
    vecs.push_back('{2'b10, 1'b0, 12'h340, 32'h00000F0F, 32'h0000A5A5, 1'b0});
    vecs.push_back('{2'b11, 1'b0, 12'h340, 32'h000000FF, 32'h0000AFAF, 1'b0});
    vecs.push_back('{2'b10, 1'b1, 12'h340, 32'h0000FFFF, 32'h0000AF00, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h340, 32'h00000000, 32'h0000AF00, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'hF14, 32'h00001234, 32'h00000000, 1'b1});
    vecs.push_back('{2'b10, 1'b1, 12'hF14, 32'h0000FFFF, 32'h00000000, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h7C0, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{2'b01, 1'b0, 12'h301, 32'h00000000, 32'h40000100, 1'b1});
    vecs.push_back('{2'b10, 1'b1, 12'h301, 32'h0000FFFF, 32'h40000100, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'h344, 32'hFFFFFFFF, 32'h00000000, 1'b1});
    vecs.push_back('{2'b01, 1'b0, 12'h304, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h304, 32'h00000000, 32'h00000880, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'h300, 32'hFFFFFFFF, 32'h00001800, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h300, 32'h00000000, 32'h00001888, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'h300, 32'h00000000, 32'h00001888, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'h305, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h305, 32'h00000000, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'h341, 32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{2'b00, 1'b0, 12'h341, 32'h00000000, 32'hFFFFFFFC, 1'b0});
    vecs.push_back('{2'b01, 1'b0, 12'hC00, 32'h00000000, 32'h00000000, 1'b1});
    vecs.push_back('{2'b00, 1'b0, 12'hF14, 32'h00000000, 32'h00000000, 1'b0});

    // Reset held for two edges; outputs stay quiet even with a CSR access in flight.
    clearIn();
    rst_n = 1'b0;
    step();
    applyStimulus(1'b1, 2'b00, 1'b0, 12'h300, 32'h0);
    pushExp("rst_rdata", SIG_RDATA, 32'h0);
    pushExp("rst_ill", SIG_ILL, 32'h0);
    pushExp("rst_pend", SIG_PEND, 32'h0);
    checkOutput();
    step();
    rst_n = 1'b1;
    readCheck(12'hB00, 32'h0);
    readCheck(12'h300, 32'h00001800);
    readCheck(12'h305, 32'h0);
    pushExp("pend_after_rst", SIG_PEND, 32'h0);
    readCheck(12'h344, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      clearIn();
      applyStimulus(1'b1, vecs[i].op, vecs[i].nowrite, vecs[i].addr, vecs[i].wdata);
      pushExp($sformatf("vec%0d_rdata", i), SIG_RDATA, vecs[i].rdata);
      pushExp($sformatf("vec%0d_ill", i), SIG_ILL, {31'b0, vecs[i].ill});
      checkOutput();
      step();
    end

    // Reset asserted in the same cycle as a write to mscratch.
    clearIn();
    rst_n = 1'b0;
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h340, 32'h00001234);
    checkOutput();
    step();
    rst_n = 1'b1;
    readCheck(12'h340, 32'h0);

    // ecall followed by mret.
    writeCsr(12'h305, 32'h80000100);
    writeCsr(12'h300, 32'h00000008);
    clearIn();
    i_ecall = 1; i_pc = 32'h80000040;
    pushExp("ecall_trap_pc", SIG_TRAP, 32'h80000100);
    checkOutput();
    step();
    pushExp("ecall_mepc", SIG_MRET, 32'h80000040);
    pushExp("ecall_mstatus", SIG_MSTATUS, 32'h00001880);
    readCheck(12'h342, 32'd11);
    readCheck(12'h343, 32'h0);
    clearIn();
    i_mret = 1;
    pushExp("mret_pc", SIG_MRET, 32'h80000040);
    checkOutput();
    step();
    pushExp("mret_mstatus", SIG_MSTATUS, 32'h00001888);
    readCheck(12'h341, 32'h80000040);

    // ebreak records the pc as mtval.
    clearIn();
    i_ebreak = 1; i_pc = 32'h80000044;
    checkOutput();
    step();
    pushExp("ebreak_mstatus", SIG_MSTATUS, 32'h00001880);
    readCheck(12'h343, 32'h80000044);
    readCheck(12'h342, 32'd3);

    // Illegal instruction beats a simultaneous CSR write.
    clearIn();
    i_illegal_inst = 1; i_tval = 32'hDEADBEEF; i_pc = 32'h80000048;
    applyStimulus(1'b1, 2'b01, 1'b0, 12'h340, 32'h00000077);
    pushExp("illinst_rdata", SIG_RDATA, 32'h0);
    checkOutput();
    step();
    pushExp("illinst_mstatus", SIG_MSTATUS, 32'h00001800);
    readCheck(12'h342, 32'd2);
    readCheck(12'h343, 32'hDEADBEEF);
    readCheck(12'h340, 32'h0);

    // Vectored external interrupt, taken together with an ecall.
    writeCsr(12'h305, 32'h80000101);
    writeCsr(12'h304, 32'h00000800);
    writeCsr(12'h300, 32'h00000008);
    clearIn();
    i_ext_irq = 1;
    pushExp("irq_pend_same_cycle", SIG_PEND, 32'h0);
    checkOutput();
    step();
    clearIn();
    i_ext_irq = 1;
    pushExp("irq_pend_next_cycle", SIG_PEND, 32'h1);
    pushExp("irq_base_no_take", SIG_TRAP, 32'h80000100);
    checkOutput();
    i_irq_take = 1; i_ecall = 1; i_pc = 32'h80000200;
    pushExp("irq_vector_pc", SIG_TRAP, 32'h8000012C);
    checkOutput();
    step();
    pushExp("irq_mstatus", SIG_MSTATUS, 32'h00001880);
    pushExp("irq_pend_after_take", SIG_PEND, 32'h0);
    readCheck(12'h342, 32'h8000000B);
    readCheck(12'h341, 32'h80000200);

    // 64-bit mcycle wrap across both halves.
    writeCsr(12'hB00, 32'hFFFFFFFE);
    writeCsr(12'hB80, 32'hFFFFFFFF);
    readCheck(12'hB80, 32'hFFFFFFFF);
    readCheck(12'hB00, 32'hFFFFFFFF);
    readCheck(12'hB80, 32'h0);
    readCheck(12'hB00, 32'h1);
    writeCsr(12'hB00, 32'h00000100);
    readCheck(12'hB00, 32'h00000100);

    // minstret counts retire cycles; a write replaces the same-cycle increment.
    writeCsr(12'hB02, 32'h0);
    for (int i = 0; i < 5; i++) begin
      clearIn();
      i_retire = (i == 0 || i == 2 || i == 3);
      checkOutput();
      step();
    end
    readCheck(12'hB02, 32'd3);
    readCheck(12'hB82, 32'h0);
    clearIn();
    i_retire = 1;
    applyStimulus(1'b1, 2'b01, 1'b0, 12'hB02, 32'h00000050);
    checkOutput();
    step();
    readCheck(12'hB02, 32'h00000050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
